vga_sync_ctrl: RTL and testbench
================================

Name: vga_sync_ctrl

Overview:
- Timing controller that sequences the character/pixel memory block: generates the pixel scan position (Posx, Posy), the sync pulses and the blanking window for a 640x480 VGA raster.
- Provides a frame-boundary handshake so display-content registers (letter positions) change only during vertical blanking.
- Sits between the board clock and the pixel memory and colour logic; its Posx/Posy feed the memory's position inputs directly.

Parameters:
- CLK_DIV, 2, system clocks per pixel tick (2 gives 25 MHz from 50 MHz); legal values 1..16.
- H_VISIBLE, 640, active pixels per line.
- H_FP, 16, horizontal front porch in pixels.
- H_SYNC, 96, hsync width in pixels.
- H_BP, 48, horizontal back porch in pixels.
- V_VISIBLE, 480, active lines.
- V_FP, 10, vertical front porch in lines.
- V_SYNC, 2, vsync width in lines.
- V_BP, 33, vertical back porch in lines.
- SYNC_POL, 0, sync active level (0 = active-low).

Ports:
- Clk  in  1  system clock.
- reset  in  1  asynchronous, active-low reset.
- Posx  out  10  horizontal pixel counter, 0..H_TOTAL-1 (H_TOTAL = H_VISIBLE+H_FP+H_SYNC+H_BP = 800).
- Posy  out  10  line counter, 0..V_TOTAL-1 (V_TOTAL = 525).
- hsync  out  1  horizontal sync.
- vsync  out  1  vertical sync.
- video_on  out  1  high while Posx < H_VISIBLE and Posy < V_VISIBLE.
- pix_tick  out  1  one-Clk pulse marking each pixel advance.
- frame_start  out  1  one-Clk pulse when the counters wrap to (0,0).
- upd_req  in  1  requester asks for a blanking-time update window; level, held until acknowledged.
- upd_ack  out  1  one-Clk grant pulse.

Behaviour:
- Reset (reset=0, asynchronous):
  - Posx=0, Posy=0, divider=0.
  - hsync and vsync at the inactive level (~SYNC_POL).
  - video_on=0, pix_tick=0, frame_start=0, upd_ack=0.
  - Reset asserted mid-frame aborts the frame immediately. The first tick after release is Clk cycle CLK_DIV.
- Divider:
  - Counts 0..CLK_DIV-1 on every Clk and wraps.
  - pix_tick is high for the Clk in which the divider wraps.
  - With CLK_DIV=1, pix_tick is constantly 1 after reset.
- Counters (advance only on pix_tick):
  - Posx increments. At H_TOTAL-1 it wraps to 0 and Posy increments.
  - Posy at V_TOTAL-1 with a Posx wrap goes to 0.
  - No other value is ever output; there are no out-of-range states.
- Per-axis FSM, states ACTIVE, FRONT, SYNC, BACK.
  - Horizontal, decoded on Posx: ACTIVE 0..639, FRONT 640..655, SYNC 656..751, BACK 752..799.
  - Vertical, decoded on Posy: ACTIVE 0..479, FRONT 480..489, SYNC 490..491, BACK 492..524.
  - Transitions occur only on pix_tick, at the boundary counts above.
- Output timing:
  - hsync, vsync and video_on are registered and computed from the next counter values. They change on the same Clk edge as Posx/Posy and are always aligned with them (zero skew, no extra latency).
  - hsync is active while H=SYNC; vsync is active while V=SYNC.
  - video_on=1 while both axes are ACTIVE. It stays 0 from reset until the first tick.
- frame_start: high for the one Clk in which the counters step from (799,524) to (0,0).
- Handshake:
  - While upd_req=1, upd_ack pulses for one Clk on the tick that moves the counters to (0,480), i.e. the start of vertical blanking.
  - At most one ack per frame.
  - upd_req rising during blanking waits for the next frame's (0,480); no mid-blank grant.
  - upd_req dropped before the grant point gives no ack.
  - Requester must deassert upd_req in the Clk after upd_ack. If upd_req is still high, the next grant is one frame later.

Decomposition:
- Shared package/header: the VGA timing constants (visible/porch/sync widths, H_TOTAL, V_TOTAL) and the FSM state encoding (2 bits: ACTIVE=0, FRONT=1, SYNC=2, BACK=3), reused by the pixel memory and colour logic.
- One natural sub-module: vga_axis_counter, instantiated twice (horizontal, vertical). It holds the counter, wrap and 4-state FSM, with inputs advance and parameters for the segment lengths, and outputs count, state and wrap.

Test Plan:
- Reset release, CLK_DIV=2:
  - pix_tick first high at Clk 2, then every 2 Clk.
  - Posx=1 after the first tick; hsync=vsync=1; video_on=1 after the first tick.
- Line timing:
  - hsync low exactly for Posx 656..751 (96 ticks = 192 Clk).
  - Posx wraps 799->0 while Posy 0->1.
  - video_on=0 for Posx 640..799.
- Frame timing:
  - vsync low only for Posy 490..491 (1600 ticks).
  - frame_start pulses once per 840000 Clk.
  - video_on=0 for Posy 480..524.
- Handshake:
  - upd_req raised at (100,200) -> single upd_ack on the tick reaching (0,480).
  - upd_req raised at (0,500) -> ack at (0,480) of the next frame.
  - upd_req held high -> one ack per frame.
- Async reset mid-frame at (300,250):
  - Outputs go to reset values in the same Clk, without waiting for an edge.
  - Counting restarts from (0,0); no spurious upd_ack or frame_start.
- CLK_DIV=1: pix_tick constant 1; line = 800 Clk; hsync low for 96 Clk.

Source files
------------

// File: rtl/vga_sync_ctrl_pkg.sv
// Shared 640x480 VGA timing constants and the per-axis segment encoding.
// The pixel memory and colour logic also use these definitions.
package vga_sync_ctrl_pkg;

  localparam int unsigned PosW = 10;

  localparam int unsigned HVisible = 640;
  localparam int unsigned HFp      = 16;
  localparam int unsigned HSync    = 96;
  localparam int unsigned HBp      = 48;
  localparam int unsigned HTotal   = HVisible + HFp + HSync + HBp;

  localparam int unsigned VVisible = 480;
  localparam int unsigned VFp      = 10;
  localparam int unsigned VSync    = 2;
  localparam int unsigned VBp      = 33;
  localparam int unsigned VTotal   = VVisible + VFp + VSync + VBp;

  typedef enum logic [1:0] {
    StActive = 2'd0,
    StFront  = 2'd1,
    StSync   = 2'd2,
    StBack   = 2'd3
  } axis_state_e;

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: position counter with wrap and the ACTIVE/FRONT/SYNC/BACK segment FSM.
// Exposes the next segment so the parent can register aligned sync/blank outputs.
module vga_axis_counter
  import vga_sync_ctrl_pkg::*;
#(
  parameter int unsigned Visible = HVisible,
  parameter int unsigned Fp      = HFp,
  parameter int unsigned Sync    = HSync,
  parameter int unsigned Bp      = HBp
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            advance_i,
  output logic [PosW-1:0] count_o,
  output axis_state_e     state_next_o,
  output logic            wrap_o
);

  localparam int unsigned Total = Visible + Fp + Sync + Bp;
  localparam logic [PosW-1:0] EndActive = PosW'(Visible - 1);
  localparam logic [PosW-1:0] EndFront  = PosW'(Visible + Fp - 1);
  localparam logic [PosW-1:0] EndSync   = PosW'(Visible + Fp + Sync - 1);
  localparam logic [PosW-1:0] EndBack   = PosW'(Total - 1);

  logic [PosW-1:0] count_q, count_d;
  axis_state_e     state_q, state_d;

  assign wrap_o = advance_i && (count_q == EndBack);

  always_comb begin
    count_d = count_q;
    state_d = state_q;
    if (advance_i) begin
      count_d = wrap_o ? '0 : count_q + PosW'(1);
      unique case (state_q)
        StActive: if (count_q == EndActive) state_d = StFront;
        StFront:  if (count_q == EndFront)  state_d = StSync;
        StSync:   if (count_q == EndSync)   state_d = StBack;
        StBack:   if (count_q == EndBack)   state_d = StActive;
        default:                            state_d = StActive;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q <= '0;
      state_q <= StActive;
    end else begin
      count_q <= count_d;
      state_q <= state_d;
    end
  end

  assign count_o      = count_q;
  assign state_next_o = state_d;

endmodule

// File: rtl/vga_sync_ctrl.sv
// VGA raster timing: pixel divider, H/V scan counters, registered sync/blank outputs,
// frame-start pulse and a grant handshake at the start of vertical blanking.
module vga_sync_ctrl
  import vga_sync_ctrl_pkg::*;
#(
  parameter int unsigned CLK_DIV   = 2,
  parameter int unsigned H_VISIBLE = HVisible,
  parameter int unsigned H_FP      = HFp,
  parameter int unsigned H_SYNC    = HSync,
  parameter int unsigned H_BP      = HBp,
  parameter int unsigned V_VISIBLE = VVisible,
  parameter int unsigned V_FP      = VFp,
  parameter int unsigned V_SYNC    = VSync,
  parameter int unsigned V_BP      = VBp,
  parameter bit          SYNC_POL  = 1'b0
) (
  input  logic            Clk,
  input  logic            reset,
  output logic [PosW-1:0] Posx,
  output logic [PosW-1:0] Posy,
  output logic            hsync,
  output logic            vsync,
  output logic            video_on,
  output logic            pix_tick,
  output logic            frame_start,
  input  logic            upd_req,
  output logic            upd_ack
);

  localparam logic [3:0]      DivLast  = 4'(CLK_DIV - 1);
  localparam logic [PosW-1:0] LastLine = PosW'(V_VISIBLE - 1);

  logic [3:0]  div_q, div_d;
  logic        tick_q;
  logic        h_wrap, v_wrap, v_advance, grant;
  axis_state_e h_state_next, v_state_next;
  logic        hsync_q, vsync_q, video_on_q, frame_start_q, upd_ack_q;

  always_comb begin
    div_d = (div_q == DivLast) ? 4'd0 : div_q + 4'd1;
  end

  // Tick is registered so it is low in reset and constant-high for CLK_DIV=1.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      div_q  <= 4'd0;
      tick_q <= 1'b0;
    end else begin
      div_q  <= div_d;
      tick_q <= (div_q == DivLast);
    end
  end

  assign v_advance = tick_q && h_wrap;

  vga_axis_counter #(
    .Visible (H_VISIBLE),
    .Fp      (H_FP),
    .Sync    (H_SYNC),
    .Bp      (H_BP)
  ) u_h_axis (
    .clk_i        (Clk),
    .rst_ni       (reset),
    .advance_i    (tick_q),
    .count_o      (Posx),
    .state_next_o (h_state_next),
    .wrap_o       (h_wrap)
  );

  vga_axis_counter #(
    .Visible (V_VISIBLE),
    .Fp      (V_FP),
    .Sync    (V_SYNC),
    .Bp      (V_BP)
  ) u_v_axis (
    .clk_i        (Clk),
    .rst_ni       (reset),
    .advance_i    (v_advance),
    .count_o      (Posy),
    .state_next_o (v_state_next),
    .wrap_o       (v_wrap)
  );

  // The only step into (0, V_VISIBLE) is the last visible line wrapping.
  assign grant = v_advance && (Posy == LastLine);

  // Decoding the next segment keeps these aligned with Posx/Posy on the same edge.
  always_ff @(posedge Clk or negedge reset) begin
    if (!reset) begin
      hsync_q       <= ~SYNC_POL;
      vsync_q       <= ~SYNC_POL;
      video_on_q    <= 1'b0;
      frame_start_q <= 1'b0;
      upd_ack_q     <= 1'b0;
    end else begin
      frame_start_q <= v_wrap;
      upd_ack_q     <= grant && upd_req;
      if (tick_q) begin
        hsync_q    <= (h_state_next == StSync) ? SYNC_POL : ~SYNC_POL;
        vsync_q    <= (v_state_next == StSync) ? SYNC_POL : ~SYNC_POL;
        video_on_q <= (h_state_next == StActive) && (v_state_next == StActive);
      end
    end
  end

  assign hsync       = hsync_q;
  assign vsync       = vsync_q;
  assign video_on    = video_on_q;
  assign pix_tick    = tick_q;
  assign frame_start = frame_start_q;
  assign upd_ack     = upd_ack_q;

endmodule

// File: tb/tb_vga_sync_ctrl.sv
// Bench for vga_sync_ctrl: full-size CLK_DIV=2 and CLK_DIV=1 instances plus a reduced
// raster instance that makes whole frames and the blanking handshake reachable quickly.
module tb_vga_sync_ctrl;

  localparam int SHV = 16, SHF = 2, SHS = 3, SHB = 3;
  localparam int SVV = 12, SVF = 2, SVS = 2, SVB = 3;

  logic Clk = 1'b0;
  logic reset = 1'b0;
  logic upd_req = 1'b0;
  logic req_off = 1'b0;

  always #5 Clk = ~Clk;

  logic [9:0] f_posx, f_posy, d_posx, d_posy, s_posx, s_posy;
  logic f_hs, f_vs, f_von, f_tick, f_fs, f_ack;
  logic d_hs, d_vs, d_von, d_tick, d_fs, d_ack;
  logic s_hs, s_vs, s_von, s_tick, s_fs, s_ack;
  logic [25:0] f_vec, d_vec, s_vec;

  assign f_vec = {f_posx, f_posy, f_hs, f_vs, f_von, f_tick, f_fs, f_ack};
  assign d_vec = {d_posx, d_posy, d_hs, d_vs, d_von, d_tick, d_fs, d_ack};
  assign s_vec = {s_posx, s_posy, s_hs, s_vs, s_von, s_tick, s_fs, s_ack};

  vga_sync_ctrl #(.CLK_DIV(2)) u_full (
    .Clk (Clk), .reset (reset), .Posx (f_posx), .Posy (f_posy), .hsync (f_hs),
    .vsync (f_vs), .video_on (f_von), .pix_tick (f_tick), .frame_start (f_fs),
    .upd_req (req_off), .upd_ack (f_ack)
  );

  vga_sync_ctrl #(.CLK_DIV(1)) u_div1 (
    .Clk (Clk), .reset (reset), .Posx (d_posx), .Posy (d_posy), .hsync (d_hs),
    .vsync (d_vs), .video_on (d_von), .pix_tick (d_tick), .frame_start (d_fs),
    .upd_req (req_off), .upd_ack (d_ack)
  );

  vga_sync_ctrl #(
    .CLK_DIV (2),
    .H_VISIBLE (SHV), .H_FP (SHF), .H_SYNC (SHS), .H_BP (SHB),
    .V_VISIBLE (SVV), .V_FP (SVF), .V_SYNC (SVS), .V_BP (SVB)
  ) u_small (
    .Clk (Clk), .reset (reset), .Posx (s_posx), .Posy (s_posy), .hsync (s_hs),
    .vsync (s_vs), .video_on (s_von), .pix_tick (s_tick), .frame_start (s_fs),
    .upd_req (upd_req), .upd_ack (s_ack)
  );

  int n_checks = 0;
  int n_pass = 0;
  int d_hs_low = 0, f_hs_low = 0, s_vs_low = 0, s_fs_cnt = 0, s_ack_cnt = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // Expected {Posx,Posy,hsync,vsync,video_on,pix_tick,frame_start,upd_ack} after edge n
  // since reset release (n=0: in reset); req is upd_req as seen at edge n.
  function automatic logic [25:0] model(input int n, input int d, input int hv, input int hf,
                                        input int hs, input int hb, input int vv, input int vf,
                                        input int vs, input int vb, input logic req);
    int ht, vt, ticks, p, x, y;
    logic tick, adv, hsn, vsn, von, fs, ack;
    if (n == 0) return {10'd0, 10'd0, 1'b1, 1'b1, 4'b0000};
    ht = hv + hf + hs + hb;
    vt = vv + vf + vs + vb;
    ticks = (n - 1) / d;
    p = ticks % (ht * vt);
    x = p % ht;
    y = p / ht;
    tick = (n >= d) && (n % d == 0);
    adv = (n >= 2) && (ticks != (n - 2) / d);
    hsn = !(x >= hv + hf && x < hv + hf + hs);
    vsn = !(y >= vv + vf && y < vv + vf + vs);
    von = (ticks >= 1) && (x < hv) && (y < vv);
    fs = adv && (p == 0);
    ack = adv && (p == vv * ht) && req;
    return {10'(x), 10'(y), hsn, vsn, von, tick, fs, ack};
  endfunction

  task automatic run(input int cycles, input bit sched);
    logic req_edge;
    logic [25:0] ef, ed, es;
    int p;
    for (int n = 1; n <= cycles; n++) begin
      req_edge = upd_req;
      @(negedge Clk);
      ef = model(n, 2, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
      ed = model(n, 1, 640, 16, 96, 48, 480, 10, 2, 33, 1'b0);
      es = model(n, 2, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, req_edge);
      check_eq($sformatf("full n=%0d", n), 32'(f_vec), 32'(ef));
      check_eq($sformatf("div1 n=%0d", n), 32'(d_vec), 32'(ed));
      check_eq($sformatf("small n=%0d", n), 32'(s_vec), 32'(es));
      if (sched) begin
        if (n <= 800 && !d_hs) d_hs_low++;
        if (n <= 1600 && !f_hs) f_hs_low++;
        if (n <= 912 && !s_vs) s_vs_low++;
        if (s_fs) s_fs_cnt++;
        if (s_ack) s_ack_cnt++;
        if (n == 2) check_eq("first_tick_posx0", 32'(f_posx), 32'd0);
        if (n == 3) begin
          check_eq("after_tick_posx1", 32'(f_posx), 32'd1);
          check_eq("after_tick_video_on", 32'(f_von), 32'd1);
          check_eq("after_tick_tick_low", 32'(f_tick), 32'd0);
        end
        if (n == 1600) check_eq("full_x799", 32'({f_posx, f_posy}), 32'({10'd799, 10'd0}));
        if (n == 1601) check_eq("full_wrap", 32'({f_posx, f_posy}), 32'({10'd0, 10'd1}));
        if (n == 801) check_eq("div1_wrap", 32'({d_posx, d_posy}), 32'({10'd0, 10'd1}));
        // Requests: (10,5) held to grant; raised in blanking; held over two frames;
        // dropped before the grant point.
        p = (n - 1) / 2;
        upd_req = (p >= 130 && p <= 287) || (p >= 360 && p <= 743) ||
                  (p >= 800 && p <= 1700) || (p >= 1874 && p <= 1923);
      end
    end
  endtask

  initial begin
    repeat (3) @(posedge Clk);
    #1;
    check_eq("rst_full", 32'(f_vec), 32'(model(0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0)));
    check_eq("rst_div1", 32'(d_vec), 32'(model(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0)));
    check_eq("rst_small", 32'(s_vec), 32'(model(0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0)));
    @(negedge Clk);
    reset = 1'b1;
    run(4450, 1'b1);
    check_eq("div1_hsync_low_clks", 32'(d_hs_low), 32'd96);
    check_eq("full_hsync_low_clks", 32'(f_hs_low), 32'd192);
    check_eq("small_vsync_low_clks", 32'(s_vs_low), 32'd96);
    check_eq("small_frame_starts", 32'(s_fs_cnt), 32'd4);
    check_eq("small_acks", 32'(s_ack_cnt), 32'd4);

    // Asynchronous reset mid-frame, between clock edges.
    #2;
    reset = 1'b0;
    upd_req = 1'b1;
    #1;
    check_eq("async_rst_full", 32'(f_vec), 32'(model(0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0)));
    check_eq("async_rst_div1", 32'(d_vec), 32'(model(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0)));
    check_eq("async_rst_small", 32'(s_vec), 32'(model(0, 2, 0, 0, 0, 0, 0, 0, 0, 0, 1'b0)));
    repeat (2) @(negedge Clk);
    reset = 1'b1;
    run(40, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
